// File: rtl/shifter_pkg.sv
// Shared definitions for the shift/normalize datapath: FSM encoding,
// direction constants and default operand geometry.
package shifter_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_STEPS = 6;
    localparam int DEF_CNT_W = 7;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } norm_state_t;

endpackage

// File: rtl/norm_step.sv
// One binary-search step of the normalizer: test a 2^k-bit window at the
// leading (left) or trailing (right) end and shift it out if it is all zero.
module norm_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int K_W   = $clog2($clog2(DEF_WIDTH))
) (
    input  logic [WIDTH-1:0] work,
    input  logic             dir,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] next,
    output logic             shifted
);

    localparam int SH_W = $clog2(WIDTH) + 1;

    logic [SH_W-1:0]  shamt_s;
    logic [WIDTH-1:0] hi_mask_s;
    logic [WIDTH-1:0] lo_mask_s;

    // Window test and conditional logical shift for the current step
    always_comb begin
        shamt_s   = SH_W'(1) << k;
        hi_mask_s = ~({WIDTH{1'b1}} >> shamt_s);
        lo_mask_s = ~({WIDTH{1'b1}} << shamt_s);
        shifted   = 1'b0;
        next      = work;
        if (dir == DIR_LEFT) begin
            shifted = ((work & hi_mask_s) == {WIDTH{1'b0}});
            if (shifted) begin
                next = work << shamt_s;
            end else begin
                next = work;
            end
        end else begin
            shifted = ((work & lo_mask_s) == {WIDTH{1'b0}});
            if (shifted) begin
                next = work >> shamt_s;
            end else begin
                next = work;
            end
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle leading/trailing zero counter and normalizer. A fixed
// STEPS-cycle binary search runs between a valid/ready input and output.
module shift_normalizer
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEPS = DEF_STEPS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    localparam int K_W = $clog2(STEPS);

    norm_state_t      state_r;
    norm_state_t      state_nxt_s;
    logic [K_W-1:0]   step_r;
    logic [WIDTH-1:0] work_r;
    logic             dir_r;
    logic [CNT_W-1:0] count_r;
    logic             zero_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CNT_W-1:0] out_count_r;
    logic             out_zero_r;

    logic [WIDTH-1:0] step_next_s;
    logic             shifted_s;
    logic [CNT_W-1:0] weight_s;
    logic [CNT_W-1:0] count_next_s;
    logic             accept_s;
    logic             finish_s;

    norm_step #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_step (
        .work    (work_r),
        .dir     (dir_r),
        .k       (step_r),
        .next    (step_next_s),
        .shifted (shifted_s)
    );

    // Step bookkeeping and next-state decode
    always_comb begin
        weight_s     = CNT_W'(1) << step_r;
        count_next_s = count_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        state_nxt_s  = state_r;
        if (shifted_s) begin
            count_next_s = count_r + weight_s;
        end else begin
            count_next_s = count_r;
        end
        case (state_r)
            IDLE: begin
                accept_s = in_valid;
                if (in_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                finish_s = (step_r == {K_W{1'b0}});
                if (finish_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and handshake flags, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Search datapath: operand capture and one window step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r  <= {K_W{1'b0}};
            work_r  <= {WIDTH{1'b0}};
            dir_r   <= 1'b0;
            count_r <= {CNT_W{1'b0}};
            zero_r  <= 1'b0;
        end else if (accept_s) begin
            step_r  <= K_W'(STEPS - 1);
            work_r  <= in_data;
            dir_r   <= in_dir;
            count_r <= {CNT_W{1'b0}};
            zero_r  <= (in_data == {WIDTH{1'b0}});
        end else if (state_r == RUN) begin
            work_r  <= step_next_s;
            count_r <= count_next_s;
            if (!finish_s) begin
                step_r <= step_r - K_W'(1);
            end
        end
    end

    // Result registers load only on entry to DONE; the all-zero operand
    // would otherwise report WIDTH-1, so it is overridden here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
            out_zero_r  <= 1'b0;
        end else if (finish_s) begin
            out_zero_r <= zero_r;
            if (zero_r) begin
                out_data_r  <= {WIDTH{1'b0}};
                out_count_r <= CNT_W'(WIDTH);
            end else begin
                out_data_r  <= step_next_s;
                out_count_r <= count_next_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;
    assign out_zero  = out_zero_r;

endmodule
